fmul_booth_iter: RTL



---
 rtl/fmul_booth_iter_if.sv | 30 +++
 rtl/fmul_booth_iter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fmul_booth_iter_if.sv
// Operand/result bus for fmul_booth_iter.
// Both channels use valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds its payload and
// valid stable until that edge. Ready may be raised without valid.
interface fmul_booth_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                     in_valid;
  logic                     in_ready;
  logic [EXP_W+MAN_W:0]     a_in;
  logic [EXP_W+MAN_W:0]     b_in;
  logic                     out_valid;
  logic                     out_ready;
  logic                     sign_out;
  logic [EXP_W+1:0]         exp_out;
  logic [2*MAN_W+1:0]       prod_out;

  // Upstream/downstream side (drives operands, accepts results)
  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, prod_out
  );

  // Multiplier side
  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, sign_out, exp_out, prod_out
  );
endinterface

// File: rtl/fmul_booth_iter.sv
// Iterative radix-4 Booth floating-point mantissa multiplier.
// Forms sign and biased exponent at accept, then retires one Booth digit
// per clock into a shared accumulator and presents the unnormalised
// product. Optional macro FMUL_ZERO_BYPASS_EN: operands with a zero
// exponent field skip the digit loop and return a zero product.
module fmul_booth_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  fmul_booth_iter_if.slave      bus,
  output logic [1:0]            dbg_state,
  output logic [1:0]            dbg_acc_hi
);

  localparam int M      = MAN_W + 1;
  localparam int N_DIG  = (MAN_W + 3) / 2;
  localparam int ACC_W  = 2 * M + 2;
  localparam int MULT_W = 2 * N_DIG + 1;
  localparam int OP_W   = EXP_W + MAN_W + 1;
  localparam int CNT_W  = $clog2(N_DIG + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = N_DIG[CNT_W-1:0];
  localparam logic [EXP_W+1:0] BIAS_V   = BIAS[EXP_W+1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   mcand_q;   // multiplicand, pre-shifted by 2k
  logic [MULT_W-1:0]  mult_q;    // multiplier, digit k sits in [2:0]
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_r;
  logic [EXP_W+1:0]   exp_r;
  logic [ACC_W-1:0]   pp;
  logic [EXP_W+1:0]   exp_sum;
  logic               accept;

  wire [EXP_W-1:0] exp_a = bus.a_in[OP_W-2 -: EXP_W];
  wire [EXP_W-1:0] exp_b = bus.b_in[OP_W-2 -: EXP_W];
  wire [MAN_W-1:0] man_a = bus.a_in[MAN_W-1:0];
  wire [MAN_W-1:0] man_b = bus.b_in[MAN_W-1:0];

`ifdef FMUL_ZERO_BYPASS_EN
  wire zero_op = (exp_a == '0) || (exp_b == '0);
`endif

  assign accept  = bus.in_valid && (state_q == IDLE);
  assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - BIAS_V;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; BUSY spends one extra cycle at CNT_LAST before DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Booth digit decode of multiplier bits [2k+2:2k]
  always_comb begin
    pp = '0;
    case (mult_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  // Operand capture and digit accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
      cnt_q   <= '0;
      sign_r  <= 1'b0;
      exp_r   <= '0;
    end else if (accept) begin
      acc_q   <= '0;
      mcand_q <= {{(ACC_W-M){1'b0}}, 1'b1, man_a};
      mult_q  <= {{(MULT_W-M-1){1'b0}}, 1'b1, man_b, 1'b0};
      sign_r  <= bus.a_in[OP_W-1] ^ bus.b_in[OP_W-1];
`ifdef FMUL_ZERO_BYPASS_EN
      // A zero operand jumps straight to the finalize cycle with a zero product
      cnt_q   <= zero_op ? CNT_LAST : '0;
      exp_r   <= zero_op ? '0 : exp_sum;
`else
      cnt_q   <= '0;
      exp_r   <= exp_sum;
`endif
    end else if (state_q == BUSY && cnt_q != CNT_LAST) begin
      acc_q   <= acc_q + pp;
      mcand_q <= mcand_q << 2;
      mult_q  <= mult_q >> 2;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sign_out  = sign_r;
  assign bus.exp_out   = exp_r;
  assign bus.prod_out  = acc_q[2*M-1:0];
  assign dbg_state     = state_q;
  assign dbg_acc_hi    = acc_q[ACC_W-1 -: 2];

endmodule
